// File: rtl/multi_tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package multi_tick_gen_pkg;

    // Default counter / divisor width.
    localparam int CNT_W_DEF = 32;

    // Default tick periods in clk cycles at 100 MHz.
    localparam logic [31:0] DIV_UART = 32'd326;         // ~307.2 kHz baud oversample
    localparam logic [31:0] DIV_SEC  = 32'd50_000_000;  // level period of 1 s
    localparam logic [31:0] DIV_MS   = 32'd50_000;      // level period of 1 ms

    // Channel index width: ceil(log2(n)) but never below one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: wrap counter, active/shadow divisor, tick pulse and level toggle.
// Latency: tick/level are registered and change on the wrap edge itself.
// Backpressure: none; free-running whenever en is high.
//
// Ports: clk/rst (sync, active-high); en run enable; restart realigns the channel;
//        wr/wr_div divisor write; def_div reset divisor; tick one-cycle enable; level square wave.
module tick_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] def_div,
    output logic             tick,
    output logic             level
);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] shd_q,   shd_d;
    logic             pend_q,  pend_d;
    logic             tick_q,  tick_d;
    logic             level_q, level_d;

    logic [CNT_W-1:0] div_eff;
    logic             wrap;

    // A zero divisor behaves as one: tick every enabled cycle.
    assign div_eff = (div_q == '0) ? CNT_W'(1) : div_q;
    assign wrap    = (cnt_q == (div_eff - CNT_W'(1)));

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        tick_d  = 1'b0;
        level_d = level_q;

        if (restart) begin
            // Realign: drop the pending period boundary and adopt any new divisor now.
            cnt_d   = '0;
            level_d = 1'b0;
            pend_d  = 1'b0;
            if (wr) begin
                div_d = wr_div;
                shd_d = wr_div;
            end else if (pend_q) begin
                div_d = shd_q;
            end
        end else if (!en) begin
            // No period in flight, so there is nothing to finish with the old divisor.
            cnt_d  = '0;
            pend_d = 1'b0;
            if (wr) begin
                div_d = wr_div;
                shd_d = wr_div;
            end else if (pend_q) begin
                div_d = shd_q;
            end
        end else if (wrap) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            level_d = ~level_q;
            pend_d  = 1'b0;
            // A write landing on the wrap edge governs the period that starts here.
            if (wr) begin
                div_d = wr_div;
                shd_d = wr_div;
            end else if (pend_q) begin
                div_d = shd_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // Defer until the wrap so the running period keeps its old length.
            if (wr) begin
                shd_d  = wr_div;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= def_div;
            shd_q   <= def_div;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;

endmodule

// File: rtl/multi_tick_gen.sv
// NUM_CH independent programmable tick-enable generators sharing one clock.
// Latency: tick/level registered at the wrap edge; cfg_err one cycle after a bad write.
// Backpressure: none; configuration writes are always accepted or flagged.
//
// Ports: clk/rst (sync, active-high); ch_en per-channel enable; restart global realign;
//        cfg_we/cfg_ch/cfg_div divisor write; cfg_err bad-index pulse; tick/level per channel.
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int                      NUM_CH  = 3,
    parameter int                      CNT_W   = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {DIV_MS, DIV_SEC, DIV_UART},
    parameter int                      IDX_W   = idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              restart,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level
);

    localparam logic [31:0] NUM_CH_U = NUM_CH;

    logic              cfg_ok;
    logic [NUM_CH-1:0] wr_vec;
    logic              cfg_err_q, cfg_err_d;

    // The index field can address more channels than exist when NUM_CH is not a power of two.
    assign cfg_ok = (32'(cfg_ch) < NUM_CH_U);

    always_comb begin
        cfg_err_d = cfg_we && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_vec[i] = cfg_we && cfg_ok && (cfg_ch == IDX_W'(i));

        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[i]),
            .restart (restart),
            .wr      (wr_vec[i]),
            .wr_div  (cfg_div),
            .def_div (DEF_DIV[i*CNT_W +: CNT_W]),
            .tick    (tick[i]),
            .level   (level[i])
        );
    end

endmodule
